// File: rtl/pe_dual_mode_if.sv
// Port bundle for one systolic-array processing element: north/west inputs
// and south/east registered outputs. The driver side uses master and the PE
// uses slave.
interface pe_dual_mode_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  mode_in;
  logic [DATA_WIDTH-1:0] psum_in;
  logic [DATA_WIDTH-1:0] weight_in;
  logic                  accept_w_in;
  logic [DATA_WIDTH-1:0] input_in;
  logic                  valid_in;
  logic                  switch_in;
  logic                  clear_in;
  logic                  drain_in;
  logic                  clear_sat_in;

  logic [DATA_WIDTH-1:0] psum_out;
  logic                  psum_valid_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  accept_w_out;
  logic [DATA_WIDTH-1:0] input_out;
  logic                  valid_out;
  logic                  switch_out;
  logic                  clear_out;
  logic                  drain_out;
  logic                  sat_flag;

  modport master (
    output mode_in, psum_in, weight_in, accept_w_in, input_in, valid_in,
           switch_in, clear_in, drain_in, clear_sat_in,
    input  psum_out, psum_valid_out, weight_out, accept_w_out, input_out,
           valid_out, switch_out, clear_out, drain_out, sat_flag
  );

  modport slave (
    input  mode_in, psum_in, weight_in, accept_w_in, input_in, valid_in,
           switch_in, clear_in, drain_in, clear_sat_in,
    output psum_out, psum_valid_out, weight_out, accept_w_out, input_out,
           valid_out, switch_out, clear_out, drain_out, sat_flag
  );
endinterface

// File: rtl/pe_dual_mode.sv
// Dual-mode systolic processing element. WS mode: double-buffered weight,
// partial sum flows south. OS mode: local accumulator, weights flow south,
// accumulator drained onto the south psum chain. Signed fixed-point with
// saturation and a sticky overflow flag. All outputs registered.
module pe_dual_mode #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  pe_dual_mode_if.slave  io
);
  localparam int DW = DATA_WIDTH;
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {MODE_WS = 1'b0, MODE_OS = 1'b1} mode_e;

  mode_e                 mode_cur, mode_q, mode_d;
  logic signed [DW-1:0]  shadow_q, shadow_d, active_q, active_d, acc_q, acc_d;
  logic                  sat_q, sat_d;
  logic [DW-1:0]         psum_q, psum_d, weight_q, weight_d, input_q, input_d;
  logic                  psum_valid_q, psum_valid_d, accept_w_q, accept_w_d;
  logic                  valid_q, valid_d, switch_q, switch_d;
  logic                  clear_q, clear_d, drain_q, drain_d;

  logic signed [DW-1:0]   w, addend, prod_sat, sum_sat;
  logic signed [2*DW-1:0] in_x, w_x, prod_full, prod_shift;
  logic signed [DW:0]     sum_full;
  logic                   prod_ovf, sum_ovf, sat_evt;

  // Multiply-shift-clamp and add-clamp datapath shared by both modes
  always_comb begin
    mode_cur   = mode_e'(io.mode_in);
    w          = (mode_cur == MODE_OS) ? $signed(io.weight_in)
                                       : (io.switch_in ? shadow_q : active_q);
    in_x       = {{DW{io.input_in[DW-1]}}, io.input_in};
    w_x        = {{DW{w[DW-1]}}, w};
    prod_full  = in_x * w_x;
    prod_shift = prod_full >>> FRAC_BITS;
    // fits in DW bits only if the top DW+1 bits are all copies of the sign
    prod_ovf   = ~((&prod_shift[2*DW-1:DW-1]) | ~(|prod_shift[2*DW-1:DW-1]));
    prod_sat   = prod_ovf ? (prod_shift[2*DW-1] ? SAT_MIN : SAT_MAX)
                          : prod_shift[DW-1:0];
    addend     = (mode_cur == MODE_OS) ? acc_q : $signed(io.psum_in);
    sum_full   = {prod_sat[DW-1], prod_sat} + {addend[DW-1], addend};
    sum_ovf    = sum_full[DW] ^ sum_full[DW-1];
    sum_sat    = sum_ovf ? (sum_full[DW] ? SAT_MIN : SAT_MAX)
                         : sum_full[DW-1:0];
  end

  // Next-state and registered-output logic for both modes
  always_comb begin
    mode_d       = mode_cur;
    shadow_d     = shadow_q;
    active_d     = active_q;
    acc_d        = acc_q;
    psum_d       = '0;
    psum_valid_d = 1'b0;
    sat_evt      = 1'b0;
    weight_d     = io.accept_w_in ? io.weight_in : '0;
    accept_w_d   = io.accept_w_in;
    input_d      = io.valid_in ? io.input_in : '0;
    valid_d      = io.valid_in;
    switch_d     = io.switch_in;
    clear_d      = io.clear_in;
    drain_d      = io.drain_in;

    if (mode_cur == MODE_WS) begin
      if (io.valid_in) begin
        psum_d       = sum_sat;
        psum_valid_d = 1'b1;
        sat_evt      = prod_ovf | sum_ovf;
      end
      if (io.accept_w_in) shadow_d = io.weight_in;
      if (io.switch_in)   active_d = shadow_q;
      acc_d = '0;
    end else begin
      psum_d       = io.drain_in ? acc_q : io.psum_in;
      psum_valid_d = io.drain_in;
      if (io.clear_in && io.valid_in) begin
        acc_d   = prod_sat;
        sat_evt = prod_ovf;
      end else if (io.clear_in) begin
        acc_d = '0;
      end else if (io.valid_in) begin
        acc_d   = sum_sat;
        sat_evt = prod_ovf | sum_ovf;
      end
    end

    if (mode_cur != mode_q) begin
      acc_d    = '0;
      shadow_d = '0;
      active_d = '0;
    end

    // a new saturation outranks a simultaneous clear request
    sat_d = sat_evt ? 1'b1 : (io.clear_sat_in ? 1'b0 : sat_q);
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_WS;
      shadow_q     <= '0;
      active_q     <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      weight_q     <= '0;
      accept_w_q   <= 1'b0;
      input_q      <= '0;
      valid_q      <= 1'b0;
      switch_q     <= 1'b0;
      clear_q      <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
      weight_q     <= weight_d;
      accept_w_q   <= accept_w_d;
      input_q      <= input_d;
      valid_q      <= valid_d;
      switch_q     <= switch_d;
      clear_q      <= clear_d;
      drain_q      <= drain_d;
    end
  end

  assign io.psum_out       = psum_q;
  assign io.psum_valid_out = psum_valid_q;
  assign io.weight_out     = weight_q;
  assign io.accept_w_out   = accept_w_q;
  assign io.input_out      = input_q;
  assign io.valid_out      = valid_q;
  assign io.switch_out     = switch_q;
  assign io.clear_out      = clear_q;
  assign io.drain_out      = drain_q;
  assign io.sat_flag       = sat_q;
endmodule
